// File: rtl/hex_display_ctrl_if.sv
// Write port of the eight-digit hex display controller.
//   wr_valid    : requester has a value to show
//   wr_data     : 32-bit value, nibble i drives HEXi
//   wr_blank_lz : blank leading zeros for this write (sampled with wr_data)
//   wr_ready    : controller is idle and can take a write
// master = requester side, slave = controller side.
interface hex_display_ctrl_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_blank_lz;
  logic        wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_blank_lz,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_blank_lz,
    output wr_ready
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Sequencing controller for eight seven-segment displays (HEX7..HEX0).
// A write is captured into shadow registers, decoded one nibble per cycle
// (digit 7 first) into staging registers with optional leading-zero
// blanking, then all eight digits are committed to the display registers
// on a single edge so no partially updated frame is ever shown.
// A free-running blink counter optionally blanks the whole display.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   wr          : write port (slave side of hex_display_ctrl_if)
//   blink_en    : live enable for the blink mask
//   busy        : decode/commit in progress
//   HEX0..HEX7  : active-low segments {g,f,e,d,c,b,a}
module hex_display_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  hex_display_ctrl_if.slave  wr,
  input  logic               blink_en,
  output logic               busy,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5,
  output logic [6:0]         HEX6,
  output logic [6:0]         HEX7
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] shadow_data;
  logic        shadow_blank;
  logic [2:0]  idx;
  logic        lz;
  logic [6:0]  stage [8];
  logic [6:0]  disp  [8];
  logic [CW-1:0] blink_cnt;
  logic        phase;
  logic        accept;
  logic [3:0]  nib;
  logic        blank_digit;
  logic        mask;

  // Hex nibble to active-low seven-segment glyph.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign accept      = wr.wr_ready & wr.wr_valid;
  assign nib         = shadow_data[{idx, 2'b00} +: 4];
  // Digit 0 is never blanked so a zero value still shows one "0".
  assign blank_digit = shadow_blank & lz & (nib == 4'h0) & (idx != 3'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/status outputs (depend on state only).
  always_comb begin
    state_next  = state;
    wr.wr_ready = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        wr.wr_ready = 1'b1;
        busy        = 1'b0;
        if (wr.wr_valid) begin
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (idx == 3'd0) begin
          state_next = COMMIT;
        end else begin
          state_next = SCAN;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture, per-digit decode into stage, and single-edge commit to disp.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data  <= 32'h0000_0000;
      shadow_blank <= 1'b0;
      idx          <= 3'd7;
      lz           <= 1'b1;
      for (int n = 0; n < 8; n++) begin
        stage[n] <= BLANK;
        disp[n]  <= BLANK;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shadow_data  <= wr.wr_data;
            shadow_blank <= wr.wr_blank_lz;
            idx          <= 3'd7;
            lz           <= 1'b1;
          end
        end
        SCAN: begin
          stage[idx] <= blank_digit ? BLANK : glyph(nib);
          lz         <= lz & (nib == 4'h0);
          if (idx != 3'd0) begin
            idx <= idx - 3'd1;
          end
        end
        COMMIT: begin
          for (int n = 0; n < 8; n++) begin
            disp[n] <= stage[n];
          end
        end
        default: begin
          idx <= 3'd7;
        end
      endcase
    end
  end

  // Free-running blink divider; phase toggles on every wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  // blink_en is live so the mask reacts within the same cycle.
  assign mask = blink_en & phase;
  assign HEX0 = mask ? BLANK : disp[0];
  assign HEX1 = mask ? BLANK : disp[1];
  assign HEX2 = mask ? BLANK : disp[2];
  assign HEX3 = mask ? BLANK : disp[3];
  assign HEX4 = mask ? BLANK : disp[4];
  assign HEX5 = mask ? BLANK : disp[5];
  assign HEX6 = mask ? BLANK : disp[6];
  assign HEX7 = mask ? BLANK : disp[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: a frame-level reference model
// checked every cycle, plus directed writes with hand-computed frames.
module tb_hex_display_ctrl;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blink_en = 1'b0;
  logic busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  hex_display_ctrl_if wif();

  hex_display_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .wr(wif), .blink_en(blink_en), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected frame for a value: digits above the highest nonzero nibble are
  // blank when blanking is requested; digit 0 always shows.
  function automatic logic [55:0] frame(input logic [31:0] v, input logic blz);
    int top;
    logic [55:0] f;
    logic [31:0] vv;
    top = -1;
    vv = v;
    f = '0;
    for (int i = 0; i < 8; i++) if (vv[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < 8; i++) begin
      if (blz && i > top && i != 0) f[7*i +: 7] = 7'h7F;
      else f[7*i +: 7] = glyph_tab[vv[4*i +: 4]];
    end
    return f;
  endfunction

  // Reference model: timer for the busy window, frame committed at its end,
  // blink phase from cycles elapsed since reset.
  logic [55:0] m_disp = {8{7'h7F}};
  int          m_left = 0;
  logic [31:0] m_val  = 32'h0;
  logic        m_blz  = 1'b0;
  int          m_cyc  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_disp <= {8{7'h7F}};
      m_left <= 0;
      m_cyc  <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_left == 0) begin
        if (wif.wr_valid) begin
          m_val  <= wif.wr_data;
          m_blz  <= wif.wr_blank_lz;
          m_left <= 9;
        end
      end else begin
        if (m_left == 1) m_disp <= frame(m_val, m_blz);
        m_left <= m_left - 1;
      end
    end
  end

  function automatic logic [55:0] dut_hex();
    return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_ready", {63'd0, wif.wr_ready}, {63'd0, (m_left == 0)});
      check("model_busy", {63'd0, busy}, {63'd0, (m_left != 0)});
      check("model_hex", {8'd0, dut_hex()},
            {8'd0, (blink_en && ((m_cyc / DIV) % 2 == 1)) ? ALL_BLANK : m_disp});
    end
  end

  // Raise a write and hold it until accepted; acc is the cycle of acceptance.
  task automatic write_val(input logic [31:0] v, input logic b, input logic keep, output int acc);
    logic ok;
    ok = 1'b0;
    acc = 0;
    wif.wr_valid = 1'b1;
    wif.wr_data = v;
    wif.wr_blank_lz = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (wif.wr_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    if (!keep) wif.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (wif.wr_ready) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
  endtask

  int a1, a2, lowc;
  logic found;
  logic [6:0] prev;

  initial begin
    wif.wr_valid = 1'b0;
    wif.wr_data = 32'h0;
    wif.wr_blank_lz = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hex", {8'd0, dut_hex()}, {8'd0, ALL_BLANK});
    check("reset_ready", {63'd0, wif.wr_ready}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);

    // Plain write: ready low for 9 cycles, frame unchanged until commit
    @(posedge clk); #1;
    write_val(32'h0123ABCD, 1'b0, 1'b0, a1);
    lowc = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (wif.wr_ready) break;
      if (lowc == 8) check("hold_before_commit", {8'd0, dut_hex()}, {8'd0, ALL_BLANK});
      lowc++;
    end
    check("ready_low_cycles", 64'(lowc), 64'd9);
    check("frame_0123ABCD", {8'd0, dut_hex()},
          {8'd0, 7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});

    // Leading-zero blanking
    write_val(32'h000000A0, 1'b1, 1'b0, a1);
    wait_idle();
    check("lz_A0", {8'd0, dut_hex()},
          {8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40});
    write_val(32'h00000000, 1'b1, 1'b0, a1);
    wait_idle();
    check("lz_zero", {8'd0, dut_hex()},
          {8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    write_val(32'h00100000, 1'b1, 1'b0, a1);
    wait_idle();
    check("lz_100000", {8'd0, dut_hex()},
          {8'd0, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    // Back-to-back with wr_valid held
    write_val(32'hCAFE0001, 1'b0, 1'b1, a1);
    write_val(32'h00BEEF42, 1'b0, 1'b0, a2);
    check("b2b_spacing", 64'(a2 - a1), 64'd10);
    wait_idle();
    check("b2b_frame", {8'd0, dut_hex()},
          {8'd0, 7'h40, 7'h40, 7'h03, 7'h06, 7'h06, 7'h0E, 7'h19, 7'h24});

    // Reset and write requested in the same cycle: reset wins
    @(posedge clk); #1;
    rst = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_data = 32'h22222222;
    @(posedge clk); #1;
    rst = 1'b0;
    wif.wr_valid = 1'b0;
    @(negedge clk);
    check("rst_wins_ready", {63'd0, wif.wr_ready}, 64'd1);
    check("rst_wins_hex", {8'd0, dut_hex()}, {8'd0, ALL_BLANK});
    @(negedge clk);
    check("rst_wins_busy", {63'd0, busy}, 64'd0);

    // Reset during the 4th scan cycle aborts the pending frame
    write_val(32'h12345678, 1'b0, 1'b0, a1);
    wait_idle();
    check("frame_12345678", {8'd0, dut_hex()},
          {8'd0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    write_val(32'hFFFFFFFF, 1'b0, 1'b0, a1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'd0, wif.wr_ready}, 64'd1);
    for (int t = 0; t < 12; t++) begin
      check("abort_blank", {8'd0, dut_hex()}, {8'd0, ALL_BLANK});
      @(negedge clk);
    end

    // Blink: HEX0 alternates 00 / 7F in 4-cycle halves
    write_val(32'h00000008, 1'b1, 1'b0, a1);
    wait_idle();
    @(posedge clk); #1 blink_en = 1'b1;
    found = 1'b0;
    @(negedge clk);
    prev = HEX0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (prev == 7'h00 && HEX0 == 7'h7F) found = 1'b1;
      prev = HEX0;
    end
    check("blink_edge_found", {63'd0, found}, 64'd1);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      check("blink_pattern", {57'd0, HEX0}, (j < 4) ? 64'h7F : 64'h00);
    end
    found = 1'b0;
    @(negedge clk);
    prev = HEX0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (prev == 7'h00 && HEX0 == 7'h7F) found = 1'b1;
      prev = HEX0;
    end
    check("blink_edge_found2", {63'd0, found}, 64'd1);
    #2 blink_en = 1'b0;
    #1 check("blink_drop_same_cycle", {57'd0, HEX0}, 64'h00);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
